// File: rtl/cs_pkg.sv
// -----------------------------------------------------------------------------
// cs_pkg
// Shared definitions for the CS window sequencer.
//   cs_state_t : controller states FILL, SCAN, DIV, WAIT, OUT
//   CS_WIN     : default window depth in samples
//   CS_IDX_W   : default width of the window index / write pointer
// -----------------------------------------------------------------------------
package cs_pkg;

  localparam int CS_WIN   = 9;
  localparam int CS_IDX_W = 4;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    SCAN = 3'd1,
    DIV  = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } cs_state_t;

endpackage

// File: rtl/cs_win_ptr.sv
// -----------------------------------------------------------------------------
// cs_win_ptr
// Circular write pointer (mod WIN) and saturating fill counter for the window.
// Ports:
//   clk, reset   clock / asynchronous active-low reset
//   inc          a sample is being written this cycle
//   clr          return pointer and fill count to empty
//   wptr         slot the next sample is written to, 0..WIN-1
//   full         window holds WIN samples
//   almost_full  window holds WIN-1 samples (next write completes it)
// -----------------------------------------------------------------------------
module cs_win_ptr
  import cs_pkg::*;
#(
  parameter int WIN   = CS_WIN,
  parameter int IDX_W = CS_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] wptr,
  output logic             full,
  output logic             almost_full
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(WIN - 1);
  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(WIN);

  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      cnt_d  = '0;
    end else if (inc) begin
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      // Count stops at WIN: from then on every write evicts the oldest entry.
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wptr        = wptr_q;
  assign full        = (cnt_q == CNT_MAX);
  assign almost_full = (cnt_q == LAST);

endmodule

// File: rtl/cs_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cs_seq_ctrl
// Control sequencer for the CS window datapath: admits samples, scans the
// 9-entry window, launches the divide and hands Y downstream. Control only.
// Ports:
//   clk, reset            clock / asynchronous active-low reset
//   x_valid, x_ready      sample handshake (x_ready only in FILL)
//   win_we, win_waddr     window RAM write strobe and slot
//   sum_upd               running-sum update (add new, subtract evicted)
//   scan_en, scan_idx,    window scan strobe, entry index and final-entry flag
//   scan_last
//   div_start, div_done   divide launch pulse / divide complete (WAIT only)
//   y_valid, y_ready      result handshake
//   busy                  controller is not in FILL
//   err                   (CS_TIMEOUT_EN only) one-cycle divide-timeout pulse
// Build option: CS_TIMEOUT_EN adds the WAIT timeout and the err port.
// -----------------------------------------------------------------------------
module cs_seq_ctrl
  import cs_pkg::*;
#(
  parameter int WIN         = CS_WIN,
  parameter int IDX_W       = CS_IDX_W,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             win_we,
  output logic [IDX_W-1:0] win_waddr,
  output logic             sum_upd,
  output logic             scan_en,
  output logic [IDX_W-1:0] scan_idx,
  output logic             scan_last,
  output logic             div_start,
  input  logic             div_done,
  output logic             y_valid,
  input  logic             y_ready,
`ifdef CS_TIMEOUT_EN
  output logic             err,
`endif
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

  // Elaboration guard: the fill counter must be able to hold WIN.
  if (IDX_W < $clog2(WIN + 1) || DIV_TIMEOUT < 1) begin : g_param_check
    $error("cs_seq_ctrl: IDX_W too small for WIN or DIV_TIMEOUT < 1");
  end

  cs_state_t        state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             accept;
  logic             full, almost_full;

  assign x_ready = (state_q == FILL);
  assign accept  = x_valid & x_ready;
  assign win_we  = accept;
  assign sum_upd = accept;

  cs_win_ptr #(
    .WIN   (WIN),
    .IDX_W (IDX_W)
  ) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .inc         (accept),
    .clr         (1'b0),
    .wptr        (win_waddr),
    .full        (full),
    .almost_full (almost_full)
  );

`ifdef CS_TIMEOUT_EN
  localparam int TO_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    scan_en    = 1'b0;
    div_start  = 1'b0;
    y_valid    = 1'b0;
`ifdef CS_TIMEOUT_EN
    err_d      = 1'b0;
    wait_cnt_d = '0;
`endif
    case (state_q)
      FILL: begin
        // The accept that completes the window, or any accept into a full
        // window, produces a new window to evaluate.
        if (accept && (almost_full || full)) state_d = SCAN;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (scan_idx_q == LAST_IDX) begin
          scan_idx_d = '0;
          state_d    = DIV;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      DIV: begin
        div_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          state_d = OUT;
        end
`ifdef CS_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          // Abandon this window's Y; the window contents stay intact.
          state_d = FILL;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      OUT: begin
        y_valid = 1'b1;
        if (y_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      scan_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
    end
  end

`ifdef CS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign scan_idx  = scan_idx_q;
  assign scan_last = scan_en && (scan_idx_q == LAST_IDX);
  assign busy      = (state_q != FILL);

endmodule

// File: tb/tb_cs_seq_ctrl.sv
module tb_cs_seq_ctrl;

  localparam int WIN = 9;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x_valid = 1'b0;
  logic       div_done = 1'b0;
  logic       y_ready = 1'b0;
  logic       x_ready, win_we, sum_upd, scan_en, scan_last, div_start, y_valid, busy;
  logic [3:0] win_waddr, scan_idx;
`ifdef CS_TIMEOUT_EN
  logic       err;
`endif

  cs_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .win_we    (win_we),
    .win_waddr (win_waddr),
    .sum_upd   (sum_upd),
    .scan_en   (scan_en),
    .scan_idx  (scan_idx),
    .scan_last (scan_last),
    .div_start (div_start),
    .div_done  (div_done),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
`ifdef CS_TIMEOUT_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle position relative to the window-completing accept.
  // m_k = 0 idle (taking samples), 1..WIN scan entry m_k-1, WIN+1 divide
  // launch, WIN+2 waiting for the divider, WIN+3 presenting Y.
  int m_fill, m_wp, m_k, m_wcnt, m_ycount;
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_wp = 0; m_k = 0; m_wcnt = 0; m_err = 0;
  endtask

  task automatic model_clock();
    bit nerr;
    nerr = 0;
    if (m_k == 0) begin
      if (x_valid) begin
        bit trig;
        trig   = (m_fill + 1 >= WIN);
        m_wp   = (m_wp + 1) % WIN;
        m_fill = (m_fill < WIN) ? m_fill + 1 : WIN;
        if (trig) m_k = 1;
      end
    end else if (m_k <= WIN) begin
      m_k++;
    end else if (m_k == WIN + 1) begin
      m_k = WIN + 2; m_wcnt = 0;
    end else if (m_k == WIN + 2) begin
      if (div_done) m_k = WIN + 3;
`ifdef CS_TIMEOUT_EN
      else if (m_wcnt == TO - 1) begin m_k = 0; nerr = 1; end
`endif
      else m_wcnt++;
    end else begin
      if (y_ready) begin
        m_k = 0;
        m_ycount++;
        $display("Y #%0d handed downstream at %0t", m_ycount, $time);
      end
    end
    m_err = nerr;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".x_ready"},   x_ready,   m_k == 0);
    chk({tag, ".win_we"},    win_we,    (m_k == 0) && x_valid);
    chk({tag, ".sum_upd"},   sum_upd,   (m_k == 0) && x_valid);
    chk({tag, ".win_waddr"}, win_waddr, m_wp);
    chk({tag, ".scan_en"},   scan_en,   (m_k >= 1) && (m_k <= WIN));
    chk({tag, ".scan_idx"},  scan_idx,  ((m_k >= 1) && (m_k <= WIN)) ? m_k - 1 : 0);
    chk({tag, ".scan_last"}, scan_last, m_k == WIN);
    chk({tag, ".div_start"}, div_start, m_k == WIN + 1);
    chk({tag, ".y_valid"},   y_valid,   m_k == WIN + 3);
    chk({tag, ".busy"},      busy,      m_k != 0);
`ifdef CS_TIMEOUT_EN
    chk({tag, ".err"},       err,       m_err);
`endif
  endtask

  task automatic drive(input bit xv, input bit dd, input bit yr, input string tag);
    @(negedge clk);
    x_valid = xv; div_done = dd; y_ready = yr;
    #1;
    check_model(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
  endtask

  task automatic step(input bit xv, input bit dd, input bit yr, input string tag);
    drive(xv, dd, yr, tag);
    tick();
  endtask

  // Run idle cycles with div_done/y_ready high until the model is back to idle.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (m_k != 0 && n < 40) begin
      step(0, 1, 1, tag);
      n++;
    end
    chk({tag, ".drain_bound"}, m_k, 0);
  endtask

  typedef struct {
    bit xv, dd, yr;
    bit xr, we;
    int waddr;
    bit sen;
    int sidx;
    bit slast, ds, yv, busy;
  } vec_t;

  vec_t tbl[34];

  initial begin
    int n, cnt_yv, cnt_xr, cnt_busy, cnt_err;
    m_ycount = 0;

    // Two full windows: first after 9 samples, second on the 10th sample.
    n = 0;
    for (int w = 0; w < 2; w++) begin
      int ns;
      ns = (w == 0) ? WIN : 1;
      for (int i = 0; i < ns; i++) begin
        tbl[n] = '{1, 0, 1, 1, 1, (w == 0) ? i : 0, 0, 0, 0, 0, 0, 0}; n++;
      end
      for (int i = 0; i < WIN; i++) begin
        tbl[n] = '{0, 0, 1, 0, 0, (w == 0) ? 0 : 1, 1, i, i == WIN - 1, 0, 0, 1}; n++;
      end
      tbl[n] = '{0, 0, 1, 0, 0, (w == 0) ? 0 : 1, 0, 0, 0, 1, 0, 1}; n++;
      tbl[n] = '{0, 1, 1, 0, 0, (w == 0) ? 0 : 1, 0, 0, 0, 0, 0, 1}; n++;
      tbl[n] = '{0, 0, 1, 0, 0, (w == 0) ? 0 : 1, 0, 0, 0, 0, 1, 1}; n++;
    end

    // Reset state
    model_reset();
    @(negedge clk); #1;
    check_model("reset");
    chk("reset.x_ready", x_ready, 1);
    chk("reset.busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table-driven sequence
    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].xv, tbl[i].dd, tbl[i].yr, "tbl");
      chk($sformatf("tbl[%0d].x_ready", i),   x_ready,   tbl[i].xr);
      chk($sformatf("tbl[%0d].win_we", i),    win_we,    tbl[i].we);
      chk($sformatf("tbl[%0d].win_waddr", i), win_waddr, tbl[i].waddr);
      chk($sformatf("tbl[%0d].scan_en", i),   scan_en,   tbl[i].sen);
      chk($sformatf("tbl[%0d].scan_idx", i),  scan_idx,  tbl[i].sidx);
      chk($sformatf("tbl[%0d].scan_last", i), scan_last, tbl[i].slast);
      chk($sformatf("tbl[%0d].div_start", i), div_start, tbl[i].ds);
      chk($sformatf("tbl[%0d].y_valid", i),   y_valid,   tbl[i].yv);
      chk($sformatf("tbl[%0d].busy", i),      busy,      tbl[i].busy);
      tick();
    end

    // y_ready held low for 5 OUT cycles
    step(1, 0, 0, "hold");
    for (int i = 0; i < WIN + 1; i++) step(0, 0, 0, "hold");
    step(0, 1, 0, "hold");
    cnt_yv = 0; cnt_xr = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, "hold");
      cnt_yv += int'(y_valid);
      cnt_xr += int'(x_ready);
      tick();
    end
    chk("hold.y_valid_cycles", cnt_yv, 5);
    chk("hold.x_ready_cycles", cnt_xr, 0);
    step(0, 0, 1, "hold");
    drive(0, 0, 0, "hold");
    chk("hold.released_busy", busy, 0);
    tick();

    // div_done pulsed during SCAN must not short-circuit WAIT
    step(1, 0, 1, "ign");
    for (int i = 0; i < WIN; i++) step(0, 1, 1, "ign");
    step(0, 0, 1, "ign");
    cnt_yv = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, "ign");
      cnt_yv += int'(y_valid);
      tick();
    end
    chk("ign.y_valid_in_wait", cnt_yv, 0);
    chk("ign.busy_in_wait", busy, 1);
    step(0, 1, 1, "ign");
    drive(0, 0, 1, "ign");
    chk("ign.y_valid_after_done", y_valid, 1);
    tick();

    // Reset asserted mid-SCAN at scan_idx 4
    step(1, 0, 1, "rst");
    for (int i = 0; i < 4; i++) step(0, 0, 1, "rst");
    drive(0, 0, 1, "rst");
    chk("rst.scan_idx_before", scan_idx, 4);
    #2 reset = 1'b0;
    #1;
    chk("rst.scan_en", scan_en, 0);
    chk("rst.scan_idx", scan_idx, 0);
    chk("rst.busy", busy, 0);
    chk("rst.win_waddr", win_waddr, 0);
    chk("rst.x_ready", x_ready, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    cnt_busy = 0;
    for (int i = 0; i < WIN - 1; i++) begin
      drive(1, 0, 1, "refill");
      cnt_busy += int'(busy);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, "refill");
      cnt_busy += int'(busy);
      tick();
    end
    chk("refill.busy_before_9th", cnt_busy, 0);
    step(1, 0, 1, "refill");
    drive(0, 0, 1, "refill");
    chk("refill.busy_after_9th", busy, 1);
    tick();
    drain("refill");

`ifdef CS_TIMEOUT_EN
    // Divider never answers: err pulse, back to FILL, no Y
    step(1, 0, 0, "tmo");
    for (int i = 0; i < WIN + 1; i++) step(0, 0, 0, "tmo");
    cnt_yv = 0; cnt_err = 0;
    for (int i = 0; i < TO + 4; i++) begin
      drive(0, 0, 0, "tmo");
      cnt_yv  += int'(y_valid);
      cnt_err += int'(err);
      tick();
    end
    chk("tmo.err_pulses", cnt_err, 1);
    chk("tmo.y_valid", cnt_yv, 0);
    chk("tmo.back_to_fill", x_ready, 1);
`else
    cnt_err = 0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
